sccb_slave_rx: RTL and testbench

SCCB_SLAVE_RX -- requirements
Module: sccb_slave_rx

---
 rtl/sccb_slave_rx.sv | 202 ++++++++++++++++++++
 tb/tb_sccb_slave_rx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave_rx.sv
// SCCB write-only slave receiver.
// Captures 3-phase writes (ID, register address, data) from an async master.
`timescale 1ns/1ps
module sccb_slave_rx #(
  parameter logic [6:0] c_id     = 7'h21,
  parameter bit         c_ack_en = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sdat_in,
  output logic       sdat_on,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    RX_BYTE,
    DNTC,
    WAIT_STOP
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic [2:0] bit_q, bit_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       got8_q, got8_d;
  logic       match_q, match_d;
  logic       cmpl_q, cmpl_d;
  logic       ack_q, ack_d;
  logic       wv_q, wv_d;
  logic       fe_q, fe_d;
  logic [7:0] wa_q, wa_d;
  logic [7:0] wd_q, wd_d;

  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall;
  logic start_det, stop_det;
  logic id_ok;
  logic go_rx;

  // [1] is the synchronized level, [2] its one-clk-old copy
  assign scl_s = scl_q[1];
  assign scl_p = scl_q[2];
  assign sda_s = sda_q[1];
  assign sda_p = sda_q[2];

  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = ~sda_s & sda_p & scl_s & scl_p;
  assign stop_det  = sda_s & ~sda_p & scl_s & scl_p;
  assign id_ok     = (shift_q == {c_id, 1'b0});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      state_q <= IDLE;
      bit_q   <= 3'd0;
      phase_q <= 2'd0;
      shift_q <= 8'h00;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      got8_q  <= 1'b0;
      match_q <= 1'b0;
      cmpl_q  <= 1'b0;
      ack_q   <= 1'b0;
      wv_q    <= 1'b0;
      fe_q    <= 1'b0;
      wa_q    <= 8'h00;
      wd_q    <= 8'h00;
    end else begin
      scl_q   <= {scl_q[1:0], sclk};
      sda_q   <= {sda_q[1:0], sdat_in};
      state_q <= state_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      got8_q  <= got8_d;
      match_q <= match_d;
      cmpl_q  <= cmpl_d;
      ack_q   <= ack_d;
      wv_q    <= wv_d;
      fe_q    <= fe_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    data_d  = data_q;
    got8_d  = got8_q;
    match_d = match_q;
    cmpl_d  = cmpl_q;
    ack_d   = ack_q;
    wv_d    = 1'b0;
    fe_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    go_rx   = 1'b0;

    if (state_q == IDLE) begin
      go_rx = start_det;
    end else if (start_det) begin
      fe_d  = match_q;
      go_rx = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      ack_d   = 1'b0;
      if (state_q != WAIT_STOP) begin
        fe_d = 1'b1;
      end else if (cmpl_q) begin
        wv_d = 1'b1;
        wa_d = addr_q;
        wd_d = data_q;
      end else begin
        fe_d = match_q;
      end
    end else begin
      unique case (state_q)
        RX_BYTE: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (bit_q == 3'd0) begin
              got8_d = 1'b1;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end else if (scl_fall && got8_q) begin
            state_d = DNTC;
            got8_d  = 1'b0;
            ack_d   = c_ack_en && ((phase_q != 2'd0) || id_ok);
          end
        end
        DNTC: begin
          if (scl_fall) begin
            ack_d = 1'b0;
            bit_d = 3'd7;
            unique case (1'b1)
              (phase_q == 2'd0): begin
                if (id_ok) begin
                  match_d = 1'b1;
                  phase_d = 2'd1;
                  state_d = RX_BYTE;
                end else begin
                  state_d = WAIT_STOP;
                end
              end
              (phase_q == 2'd1): begin
                addr_d  = shift_q;
                phase_d = 2'd2;
                state_d = RX_BYTE;
              end
              default: begin
                data_d  = shift_q;
                cmpl_d  = 1'b1;
                state_d = WAIT_STOP;
              end
            endcase
          end
        end
        default: ;
      endcase
    end

    // a start always reopens reception at the ID phase
    if (go_rx) begin
      state_d = RX_BYTE;
      bit_d   = 3'd7;
      phase_d = 2'd0;
      got8_d  = 1'b0;
      match_d = 1'b0;
      cmpl_d  = 1'b0;
      ack_d   = 1'b0;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    sdat_on   = c_ack_en & ack_q;
    wr_valid  = wv_q;
    frame_err = fe_q;
    wr_addr   = wa_q;
    wr_data   = wd_q;
  end

endmodule

// File: tb/tb_sccb_slave_rx.sv
// Bench for sccb_slave_rx: bit-banged SCCB master, directed table,
// hand sequences and randomized writes against a transaction-level model.
`timescale 1ns/1ps
module tb_sccb_slave_rx;

  typedef struct {
    logic [7:0] id;
    logic [7:0] addr;
    logic [7:0] data;
    int         tb;
    int         tk;
    int         extra;
    int         ev;
    int         ef;
    int         eack;
    logic [7:0] ea;
    logic [7:0] ed;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;

  logic       on_a, v_a, b_a, f_a;
  logic [7:0] a_a, d_a;
  logic       on_b, v_b, b_b, f_b;
  logic [7:0] a_b, d_b;

  int q = 650;
  int total = 0;
  int bad = 0;

  int vcnt_a = 0, fcnt_a = 0, ackcnt = 0;
  int vcnt_b = 0, fcnt_b = 0, onb_cnt = 0, both_cnt = 0;
  logic on_a_prev = 1'b0;
  time last_v = 0, last_f = 0;
  int s_va, s_fa, s_ack, s_vb, s_fb;

  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_data = 8'h00;

  assign sda_bus = sda_m & ~on_a;

  always #10 clk = ~clk;

  sccb_slave_rx #(.c_id(7'h21), .c_ack_en(1'b1)) dut_a (
    .clk(clk), .rst(rst), .sclk(scl_m), .sdat_in(sda_bus),
    .sdat_on(on_a), .wr_valid(v_a), .wr_addr(a_a),
    .wr_data(d_a), .busy(b_a), .frame_err(f_a)
  );

  sccb_slave_rx dut_b (
    .clk(clk), .rst(rst), .sclk(scl_m), .sdat_in(sda_bus),
    .sdat_on(on_b), .wr_valid(v_b), .wr_addr(a_b),
    .wr_data(d_b), .busy(b_b), .frame_err(f_b)
  );

  always @(negedge clk) begin
    on_a_prev <= on_a;
    if (v_a) vcnt_a <= vcnt_a + 1;
    if (f_a) fcnt_a <= fcnt_a + 1;
    if (v_b) vcnt_b <= vcnt_b + 1;
    if (f_b) fcnt_b <= fcnt_b + 1;
    if (on_a && !on_a_prev) ackcnt <= ackcnt + 1;
    if (on_b) onb_cnt <= onb_cnt + 1;
    if ((v_a && f_a) || (v_b && f_b)) both_cnt <= both_cnt + 1;
    if (v_a) last_v <= $time;
    if (f_a) last_f <= $time;
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;
    #(q);
    scl_m = 1'b1;
    #(2 * q);
    scl_m = 1'b0;
    #(q);
  endtask

  task automatic send_byte(input logic [7:0] x);
    for (int i = 7; i >= 0; i--) send_bit(x[i]);
    send_bit(1'b1);
  endtask

  task automatic do_start();
    sda_m = 1'b0;
    #(q);
    scl_m = 1'b0;
    #(q);
  endtask

  task automatic do_rstart();
    sda_m = 1'b1;
    #(q);
    scl_m = 1'b1;
    #(q);
    do_start();
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    #(q);
    scl_m = 1'b1;
    #(q);
    sda_m = 1'b1;
    #(4 * q);
  endtask

  task automatic snap();
    s_va  = vcnt_a;
    s_fa  = fcnt_a;
    s_ack = ackcnt;
    s_vb  = vcnt_b;
    s_fb  = fcnt_b;
  endtask

  task automatic check_txn(input string nm, input int ev, input int ef,
                           input int eack, input logic [7:0] ea,
                           input logic [7:0] ed);
    repeat (10) @(negedge clk);
    chk({nm, ":valid_a"}, vcnt_a - s_va, ev);
    chk({nm, ":ferr_a"}, fcnt_a - s_fa, ef);
    chk({nm, ":acks"}, ackcnt - s_ack, eack);
    chk({nm, ":addr_a"}, a_a, ea);
    chk({nm, ":data_a"}, d_a, ed);
    chk({nm, ":busy_a"}, b_a, 0);
    chk({nm, ":valid_b"}, vcnt_b - s_vb, ev);
    chk({nm, ":ferr_b"}, fcnt_b - s_fb, ef);
    chk({nm, ":addr_b"}, a_b, ea);
    chk({nm, ":data_b"}, d_b, ed);
    chk({nm, ":busy_b"}, b_b, 0);
    chk({nm, ":ack_off_b"}, onb_cnt, 0);
    chk({nm, ":overlap"}, both_cnt, 0);
  endtask

  // tb < 3: stop after tk bits of byte tb; extra: junk bytes before stop
  task automatic run_txn(input logic [7:0] id, input logic [7:0] ad,
                         input logic [7:0] dt, input int tb, input int tk,
                         input int extra);
    logic [7:0] by [3];
    by[0] = id;
    by[1] = ad;
    by[2] = dt;
    do_start();
    chk("busy_after_start", b_a, 1);
    for (int i = 0; i < 3; i++) begin
      if (i == tb) begin
        for (int k = 0; k < tk; k++) send_bit(by[i][7-k]);
        do_stop();
        return;
      end
      send_byte(by[i]);
    end
    for (int e = 0; e < extra; e++) send_byte(8'hA5);
    do_stop();
  endtask

  // transaction-level reference: what one write should produce
  task automatic model(input logic [7:0] id, input logic [7:0] ad,
                       input logic [7:0] dt, input int tb,
                       output int ev, output int ef, output int eack);
    bit match;
    match = (id == 8'h42);
    if (tb < 3) begin
      ev   = 0;
      ef   = (tb == 0 || match) ? 1 : 0;
      eack = match ? tb : 0;
    end else begin
      ev   = match ? 1 : 0;
      ef   = 0;
      eack = match ? 3 : 0;
      if (match) begin
        m_addr = ad;
        m_data = dt;
      end
    end
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'h42, 8'h12, 8'h80, 3, 0, 0, 1, 0, 3, 8'h12, 8'h80};
    tbl[1] = '{8'h60, 8'h3A, 8'h04, 3, 0, 0, 0, 0, 0, 8'h12, 8'h80};
    tbl[2] = '{8'h42, 8'h11, 8'h01, 3, 0, 0, 1, 0, 3, 8'h11, 8'h01};
    tbl[3] = '{8'h42, 8'h55, 8'hAA, 2, 4, 0, 0, 1, 2, 8'h11, 8'h01};
    tbl[4] = '{8'h42, 8'h77, 8'hE1, 3, 0, 1, 1, 0, 3, 8'h77, 8'hE1};
    tbl[5] = '{8'h43, 8'h20, 8'h30, 3, 0, 0, 0, 0, 0, 8'h77, 8'hE1};

    repeat (4) @(negedge clk);
    chk("rst:valid", v_a, 0);
    chk("rst:ferr", f_a, 0);
    chk("rst:busy", b_a, 0);
    chk("rst:sdat_on", on_a, 0);
    chk("rst:addr", a_a, 0);
    chk("rst:data", d_a, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    q = 650;
    foreach (tbl[i]) begin
      snap();
      run_txn(tbl[i].id, tbl[i].addr, tbl[i].data,
              tbl[i].tb, tbl[i].tk, tbl[i].extra);
      check_txn($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ef,
                tbl[i].eack, tbl[i].ea, tbl[i].ed);
    end
    m_addr = 8'h77;
    m_data = 8'hE1;

    q = 200;
    // stop with no preceding start
    snap();
    scl_m = 1'b0;
    #(q);
    sda_m = 1'b0;
    #(q);
    scl_m = 1'b1;
    #(q);
    sda_m = 1'b1;
    #(4 * q);
    check_txn("idle_stop", 0, 0, 0, m_addr, m_data);

    // repeated start after the address byte
    snap();
    do_start();
    send_byte(8'h42);
    send_byte(8'h33);
    do_rstart();
    send_byte(8'h42);
    send_byte(8'h40);
    send_byte(8'hD0);
    do_stop();
    m_addr = 8'h40;
    m_data = 8'hD0;
    check_txn("rstart", 1, 1, 5, m_addr, m_data);
    chk("rstart:order", (last_f < last_v) ? 1 : 0, 1);

    // reset pulse in the middle of the address byte
    snap();
    do_start();
    send_byte(8'h42);
    for (int k = 0; k < 3; k++) send_bit(1'(8'h5A >> (7 - k)));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst:busy", b_a, 0);
    chk("midrst:sdat_on", on_a, 0);
    rst = 1'b1;
    for (int k = 3; k < 8; k++) send_bit(1'(8'h5A >> (7 - k)));
    send_bit(1'b1);
    send_byte(8'h66);
    do_stop();
    m_addr = 8'h00;
    m_data = 8'h00;
    check_txn("midrst", 0, 0, 1, m_addr, m_data);

    snap();
    run_txn(8'h42, 8'h15, 8'h02, 3, 0, 0);
    m_addr = 8'h15;
    m_data = 8'h02;
    check_txn("after_rst", 1, 0, 3, m_addr, m_data);

    for (int n = 0; n < 16; n++) begin
      logic [7:0] id, ad, dt;
      int tb, tk, ex, ev, ef, eack;
      q  = $urandom_range(200, 100);
      id = ($urandom_range(1, 0) == 1) ? 8'h42 : 8'($urandom);
      ad = 8'($urandom);
      dt = 8'($urandom);
      tb = ($urandom_range(9, 0) < 7) ? 3 : $urandom_range(2, 0);
      tk = $urandom_range(7, 1);
      ex = $urandom_range(1, 0);
      snap();
      run_txn(id, ad, dt, tb, tk, ex);
      model(id, ad, dt, tb, ev, ef, eack);
      check_txn($sformatf("rnd%0d", n), ev, ef, eack, m_addr, m_data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
